// File: rtl/subtractor_m.sv
// Bit-serial unsigned subtractor: one full-subtractor stage per clock, LSB first.
// Result is {zeros, borrow, A-B} with a start/done handshake.
module subtractor_m #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   adout0,
    input  logic [WIDTH-1:0]   bdout0,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] tsub,
    output logic               zero
);
    // state  | meaning
    // IDLE   | waiting for start
    // RUN    | one difference bit per cycle, bit_cnt = bit being processed
    // DONE   | result pulse cycle; start here re-enters RUN directly
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_bw;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_diff;
    logic               r_done;
    logic [2*WIDTH-1:0] r_tsub;
    logic               r_zero;

    logic               w_ai;
    logic               w_bi;
    logic               w_di;
    logic               w_bw_nxt;
    logic [WIDTH-1:0]   w_diff_nxt;
    logic               w_last;
    logic               w_accept;

    // Operands are shifted right each cycle so the current bit is always bit 0.
    assign w_ai       = r_a[0];
    assign w_bi       = r_b[0];
    assign w_di       = w_ai ^ w_bi ^ r_bw;
    assign w_bw_nxt   = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_bw);
    assign w_diff_nxt = {w_di, {(WIDTH-1){1'b0}}} | (r_diff >> 1);
    assign w_last     = (r_state == S_RUN) && (r_cnt == CNT_LAST);
    assign w_accept   = start && ((r_state == S_IDLE) || (r_state == S_DONE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_bw    <= 1'b0;
            r_cnt   <= '0;
            r_diff  <= '0;
            r_done  <= 1'b0;
            r_tsub  <= '0;
            r_zero  <= 1'b0;
        end else begin
            r_done <= w_last;
            case (r_state)
                S_RUN: begin
                    r_a    <= r_a >> 1;
                    r_b    <= r_b >> 1;
                    r_bw   <= w_bw_nxt;
                    r_diff <= w_diff_nxt;
                    if (w_last) begin
                        r_state <= S_DONE;
                        r_tsub  <= {{(WIDTH-1){1'b0}}, w_bw_nxt, w_diff_nxt};
                        r_zero  <= (w_diff_nxt == '0);
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    if (w_accept) begin
                        r_state <= S_RUN;
                        r_a     <= adout0;
                        r_b     <= bdout0;
                        r_bw    <= 1'b0;
                        r_cnt   <= '0;
                        r_diff  <= '0;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign busy = (r_state == S_RUN);
    assign done = r_done;
    assign tsub = r_tsub;
    assign zero = r_zero;

endmodule

// File: tb/tb_subtractor_m.sv
// Directed and exhaustive checks of subtractor_m with WIDTH=4.
module tb_subtractor_m;
    localparam int W = 4;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [W-1:0]   adout0;
    logic [W-1:0]   bdout0;
    logic           busy;
    logic           done;
    logic [2*W-1:0] tsub;
    logic           zero;

    int n_cmp = 0;
    int n_err = 0;

    subtractor_m #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .adout0 (adout0),
        .bdout0 (bdout0),
        .busy   (busy),
        .done   (done),
        .tsub   (tsub),
        .zero   (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] t;
        logic       z;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Accept one operation from IDLE, then check latency, result and return to IDLE.
    task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                          input logic [7:0] et, input logic ez, input string nm);
        int n;
        adout0 = a;
        bdout0 = b;
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        adout0 = ~a;
        bdout0 = ~b;
        chk({nm, " busy"}, busy, 1);
        n = 0;
        while (!done && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk({nm, " latency"}, n, W);
        chk({nm, " tsub"}, tsub, et);
        chk({nm, " zero"}, zero, ez);
        @(posedge clk); #1;
        chk({nm, " done_drop"}, done, 0);
        chk({nm, " idle"}, busy, 0);
    endtask

    function automatic logic [7:0] ref_t(input logic [3:0] a, input logic [3:0] b);
        logic [4:0] r;
        r = {1'b0, a} - {1'b0, b};
        return {3'b000, r[4], r[3:0]};
    endfunction

    vec_t vecs[10];
    vec_t seq[4];

    initial begin
        vecs[0] = '{4'h9, 4'h4, 8'h05, 1'b0};
        vecs[1] = '{4'h4, 4'h9, 8'h1B, 1'b0};
        vecs[2] = '{4'h0, 4'hF, 8'h11, 1'b0};
        vecs[3] = '{4'hF, 4'hF, 8'h00, 1'b1};
        vecs[4] = '{4'h0, 4'h0, 8'h00, 1'b1};
        vecs[5] = '{4'h7, 4'h3, 8'h04, 1'b0};
        vecs[6] = '{4'h3, 4'h7, 8'h1C, 1'b0};
        vecs[7] = '{4'hF, 4'h0, 8'h0F, 1'b0};
        vecs[8] = '{4'h1, 4'h2, 8'h1F, 1'b0};
        vecs[9] = '{4'h8, 4'h8, 8'h00, 1'b1};

        seq[0] = '{4'hA, 4'h3, 8'h07, 1'b0};
        seq[1] = '{4'h2, 4'h5, 8'h1D, 1'b0};
        seq[2] = '{4'h6, 4'h6, 8'h00, 1'b1};
        seq[3] = '{4'hC, 4'h1, 8'h0B, 1'b0};

        rst_n  = 1'b0;
        start  = 1'b0;
        adout0 = '0;
        bdout0 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst tsub", tsub, 0);
        chk("rst zero", zero, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].t, vecs[i].z, $sformatf("vec%0d", i));

        // start held high: accept edges every W+1 cycles, each result from its own operands
        for (int k = 0; k < 4; k++) begin
            adout0 = seq[k].a;
            bdout0 = seq[k].b;
            start  = 1'b1;
            @(posedge clk); #1;
            chk($sformatf("b2b%0d busy", k), busy, 1);
            adout0 = ~seq[k].a;
            bdout0 = seq[k].a;
            repeat (W) @(posedge clk);
            #1;
            chk($sformatf("b2b%0d done", k), done, 1);
            chk($sformatf("b2b%0d tsub", k), tsub, seq[k].t);
            chk($sformatf("b2b%0d zero", k), zero, seq[k].z);
        end
        start = 1'b0;
        @(posedge clk); #1;
        chk("b2b end done", done, 0);
        chk("b2b end busy", busy, 0);

        // start pulsed mid-RUN is ignored; previous result holds until completion
        adout0 = 4'h9;
        bdout0 = 4'h4;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("ign hold tsub", tsub, 8'h0B);
        adout0 = 4'h4;
        bdout0 = 4'h9;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("ign still busy", busy, 1);
        @(posedge clk); #1;
        chk("ign done", done, 1);
        chk("ign tsub", tsub, 8'h05);
        @(posedge clk); #1;
        chk("ign no rerun", busy, 0);
        chk("ign done drop", done, 0);

        // async reset mid-RUN at bit 2
        adout0 = 4'h3;
        bdout0 = 4'h1;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mrst busy", busy, 0);
        chk("mrst done", done, 0);
        chk("mrst tsub", tsub, 0);
        chk("mrst zero", zero, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(4'h3, 4'h1, 8'h02, 1'b0, "post_rst");

        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                run_op(4'(a), 4'(b), ref_t(4'(a), 4'(b)), (4'(a) == 4'(b)),
                       $sformatf("sweep_%0h_%0h", a, b));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
